dot_max_engine: RTL and testbench



---
 rtl/dot_max_pkg.sv | 21 ++
 rtl/dot_max_mac.sv | 55 +++++
 rtl/dot_max_engine.sv | 156 +++++++++++++++
 tb/tb_dot_max_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_max_pkg.sv
// ------------------------------------------------------------------
// dot_max_pkg: shared FSM encoding and width helper for dot_max_engine
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dot_max_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  function automatic int acc_width(input int dw, input int lanes);
    return 2 * dw + $clog2(lanes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_max_mac.sv
// ------------------------------------------------------------------
// dot_max_mac: lane-multiplexed single multiplier with accumulator
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dot_max_mac import dot_max_pkg::*; #(
  parameter int DW     = 8,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int ACC_W  = acc_width(DW, LANES),
  localparam int LW    = $clog2(LANES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES-1:0][DW-1:0]   in_vec,
  input  logic [LANES-1:0][DW-1:0]   w_vec,
  input  logic [LW-1:0]              lane,
  input  logic                       clr,
  input  logic                       en,
  output logic [ACC_W-1:0]           acc
);

  logic [DW-1:0]           x_sel;
  logic [DW-1:0]           w_sel;
  logic signed [DW:0]      x_ext;
  logic signed [DW:0]      w_ext;
  logic signed [ACC_W-1:0] x_wide;
  logic signed [ACC_W-1:0] w_wide;
  logic signed [ACC_W-1:0] prod;

  // One extra bit lets unsigned and signed operands share a signed multiplier.
  always_comb begin
    x_sel  = in_vec[lane];
    w_sel  = w_vec[lane];
    x_ext  = {(SIGNED != 0) && x_sel[DW-1], x_sel};
    w_ext  = {(SIGNED != 0) && w_sel[DW-1], w_sel};
    x_wide = ACC_W'(x_ext);
    w_wide = ACC_W'(w_ext);
    prod   = x_wide * w_wide;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dot_max_engine.sv
// ------------------------------------------------------------------
// dot_max_engine: streamed LANES-wide dot product with running maximum
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dot_max_engine import dot_max_pkg::*; #(
  parameter int DW     = 8,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int IDX_W  = 8,
  localparam int ACC_W = acc_width(DW, LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  input  logic              in_sel,
  output logic              in_ready,
  input  logic              clear_max,
  output logic              busy,
  output logic              result_valid,
  output logic [ACC_W-1:0]  dot_out,
  output logic [ACC_W-1:0]  max_out,
  output logic [IDX_W-1:0]  max_idx,
  output logic              max_valid
);

  localparam int LW = $clog2(LANES);

  state_t                   state;
  state_t                   state_nxt;
  logic [LANES-1:0][DW-1:0] w_reg;
  logic [LANES-1:0][DW-1:0] x_reg;
  logic [LW-1:0]            in_cnt;
  logic [LW-1:0]            lane;
  logic [IDX_W-1:0]         vec_cnt;
  logic [ACC_W-1:0]         acc;
  logic                     w_acc;
  logic                     x_acc;
  logic                     last_beat;
  logic                     lane_last;
  logic                     acc_gt;

  always_comb begin
    w_acc     = in_valid && in_ready && in_sel;
    x_acc     = in_valid && in_ready && !in_sel;
    last_beat = x_acc && (in_cnt == LW'(LANES - 1));
    lane_last = (lane == LW'(LANES - 1));
    acc_gt    = (SIGNED != 0) ? ($signed(acc) > $signed(max_out)) : (acc > max_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (last_beat) state_nxt = ST_MAC;
      ST_MAC:  if (lane_last) state_nxt = ST_CMP;
      ST_CMP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_MAC);
  end

  // New beats enter the top lane so the first beat of a vector ends in lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg  <= '0;
      x_reg  <= '0;
      in_cnt <= '0;
      lane   <= '0;
    end else begin
      if (w_acc) begin
        w_reg <= {in_data, w_reg[LANES-1:1]};
      end
      if (x_acc) begin
        x_reg  <= {in_data, x_reg[LANES-1:1]};
        in_cnt <= last_beat ? '0 : in_cnt + LW'(1);
      end
      lane <= (state == ST_MAC && !lane_last) ? lane + LW'(1) : '0;
    end
  end

  dot_max_mac #(
    .DW     (DW),
    .LANES  (LANES),
    .SIGNED (SIGNED),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vec (x_reg),
    .w_vec  (w_reg),
    .lane   (lane),
    .clr    (last_beat),
    .en     (state == ST_MAC),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      dot_out      <= '0;
    end else begin
      result_valid <= (state == ST_CMP);
      if (state == ST_CMP) begin
        dot_out <= acc;
      end
    end
  end

  // A clear landing on the CMP edge adopts the current result as entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_out   <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
      vec_cnt   <= '0;
    end else if (clear_max) begin
      if (state == ST_CMP) begin
        max_out   <= acc;
        max_idx   <= '0;
        max_valid <= 1'b1;
        vec_cnt   <= IDX_W'(1);
      end else begin
        max_out   <= '0;
        max_idx   <= '0;
        max_valid <= 1'b0;
        vec_cnt   <= '0;
      end
    end else if (state == ST_CMP) begin
      if (!max_valid || acc_gt) begin
        max_out   <= acc;
        max_idx   <= vec_cnt;
        max_valid <= 1'b1;
      end
      if (vec_cnt != {IDX_W{1'b1}}) begin
        vec_cnt <= vec_cnt + IDX_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_max_engine.sv
// ------------------------------------------------------------------
// tb_dot_max_engine: directed checks on unsigned and signed instances
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dot_max_engine;

  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             u_rst_n, s_rst_n;
  logic [7:0]       u_in_data, s_in_data;
  logic             u_in_valid, s_in_valid;
  logic             u_in_sel, s_in_sel;
  logic             u_in_ready, s_in_ready;
  logic             u_clear_max, s_clear_max;
  logic             u_busy, s_busy;
  logic             u_result_valid, s_result_valid;
  logic [ACC_W-1:0] u_dot_out, s_dot_out;
  logic [ACC_W-1:0] u_max_out, s_max_out;
  logic [7:0]       u_max_idx, s_max_idx;
  logic             u_max_valid, s_max_valid;

  int passed = 0;
  int total  = 0;
  int cyc;

  always #5 clk = ~clk;

  dot_max_engine #(.DW(8), .LANES(4), .SIGNED(0), .IDX_W(8)) u_dut (
    .clk          (clk),
    .rst_n        (u_rst_n),
    .in_data      (u_in_data),
    .in_valid     (u_in_valid),
    .in_sel       (u_in_sel),
    .in_ready     (u_in_ready),
    .clear_max    (u_clear_max),
    .busy         (u_busy),
    .result_valid (u_result_valid),
    .dot_out      (u_dot_out),
    .max_out      (u_max_out),
    .max_idx      (u_max_idx),
    .max_valid    (u_max_valid)
  );

  dot_max_engine #(.DW(8), .LANES(4), .SIGNED(1), .IDX_W(8)) s_dut (
    .clk          (clk),
    .rst_n        (s_rst_n),
    .in_data      (s_in_data),
    .in_valid     (s_in_valid),
    .in_sel       (s_in_sel),
    .in_ready     (s_in_ready),
    .clear_max    (s_clear_max),
    .busy         (s_busy),
    .result_valid (s_result_valid),
    .dot_out      (s_dot_out),
    .max_out      (s_max_out),
    .max_idx      (s_max_idx),
    .max_valid    (s_max_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic beat(input bit s, input bit sel, input logic [7:0] d);
    int n;
    n = 0;
    if (s) begin s_in_valid = 1'b1; s_in_sel = sel; s_in_data = d; end
    else   begin u_in_valid = 1'b1; u_in_sel = sel; u_in_data = d; end
    while (((s ? s_in_ready : u_in_ready) !== 1'b1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      $error("FAIL ready_timeout: observed in_ready low for %0d cycles expected high", n);
    end
    @(posedge clk); #1;
    if (s) s_in_valid = 1'b0;
    else   u_in_valid = 1'b0;
  endtask

  task automatic vec4(input bit s, input bit sel, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    beat(s, sel, a);
    beat(s, sel, b);
    beat(s, sel, c);
    beat(s, sel, d);
  endtask

  task automatic wait_result(input bit s, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (((s ? s_result_valid : u_result_valid) !== 1'b1) && n < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    u_rst_n = 1'b0; s_rst_n = 1'b0;
    u_in_data = '0; u_in_valid = 1'b0; u_in_sel = 1'b0; u_clear_max = 1'b0;
    s_in_data = '0; s_in_valid = 1'b0; s_in_sel = 1'b0; s_clear_max = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    u_rst_n = 1'b1; s_rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_in_ready", u_in_ready, 1);
    chk("rst_busy", u_busy, 0);
    chk("rst_result_valid", u_result_valid, 0);
    chk("rst_dot", u_dot_out, 0);
    chk("rst_max", u_max_out, 0);
    chk("rst_idx", u_max_idx, 0);
    chk("rst_max_valid", u_max_valid, 0);
    chk("rst_s_max_valid", s_max_valid, 0);

    // first vector: 1*10+2*20+3*30+4*40 = 300
    vec4(0, 1, 8'd1, 8'd2, 8'd3, 8'd4);
    vec4(0, 0, 8'd10, 8'd20, 8'd30, 8'd40);
    chk("mac_in_ready", u_in_ready, 0);
    chk("mac_busy", u_busy, 1);
    wait_result(0, cyc);
    chk("v0_latency", cyc, 5);
    chk("v0_dot", u_dot_out, 300);
    chk("v0_max", u_max_out, 300);
    chk("v0_idx", u_max_idx, 0);
    chk("v0_max_valid", u_max_valid, 1);
    @(posedge clk); #1;
    chk("v0_pulse_end", u_result_valid, 0);

    // inputs 1s -> 10; weight beat held through MAC/CMP must not shift
    vec4(0, 0, 8'd1, 8'd1, 8'd1, 8'd1);
    u_in_valid = 1'b1; u_in_sel = 1'b1; u_in_data = 8'd255;
    wait_result(0, cyc);
    chk("v1_latency", cyc, 5);
    chk("v1_dot_held", u_dot_out, 10);
    chk("v1_max", u_max_out, 300);
    chk("v1_idx", u_max_idx, 0);
    chk("v1_ready_back", u_in_ready, 1);
    @(posedge clk); #1;
    u_in_valid = 1'b0;
    beat(0, 1, 8'd255);
    beat(0, 1, 8'd255);
    beat(0, 1, 8'd255);

    // 4*255*255 = 260100, new max at index 2
    vec4(0, 0, 8'd255, 8'd255, 8'd255, 8'd255);
    wait_result(0, cyc);
    chk("v2_dot", u_dot_out, 260100);
    chk("v2_max", u_max_out, 260100);
    chk("v2_idx", u_max_idx, 2);

    // tie keeps older index
    vec4(0, 0, 8'd255, 8'd255, 8'd255, 8'd255);
    wait_result(0, cyc);
    chk("v3_tie_dot", u_dot_out, 260100);
    chk("v3_tie_idx", u_max_idx, 2);

    // asynchronous reset two cycles into MAC
    vec4(0, 1, 8'd1, 8'd2, 8'd3, 8'd4);
    vec4(0, 0, 8'd5, 8'd5, 8'd5, 8'd5);
    @(posedge clk); @(posedge clk); #1;
    u_rst_n = 1'b0;
    #1;
    chk("arst_dot", u_dot_out, 0);
    chk("arst_max", u_max_out, 0);
    chk("arst_idx", u_max_idx, 0);
    chk("arst_max_valid", u_max_valid, 0);
    chk("arst_busy", u_busy, 0);
    chk("arst_in_ready", u_in_ready, 1);
    @(negedge clk);
    u_rst_n = 1'b1;
    @(posedge clk); #1;
    vec4(0, 1, 8'd1, 8'd2, 8'd3, 8'd4);
    vec4(0, 0, 8'd10, 8'd20, 8'd30, 8'd40);
    wait_result(0, cyc);
    chk("post_rst_latency", cyc, 5);
    chk("post_rst_dot", u_dot_out, 300);
    chk("post_rst_idx", u_max_idx, 0);

    // clear_max on the CMP edge of the dot=10 vector
    vec4(0, 0, 8'd1, 8'd1, 8'd1, 8'd1);
    repeat (4) begin @(posedge clk); #1; end
    u_clear_max = 1'b1;
    @(posedge clk); #1;
    u_clear_max = 1'b0;
    chk("clr_cmp_rv", u_result_valid, 1);
    chk("clr_cmp_dot", u_dot_out, 10);
    chk("clr_cmp_max", u_max_out, 10);
    chk("clr_cmp_idx", u_max_idx, 0);
    chk("clr_cmp_max_valid", u_max_valid, 1);
    vec4(0, 0, 8'd100, 8'd100, 8'd100, 8'd100);
    wait_result(0, cyc);
    chk("clr_next_max", u_max_out, 1000);
    chk("clr_next_idx", u_max_idx, 1);

    // clear_max while idle leaves dot_out alone
    u_clear_max = 1'b1;
    @(posedge clk); #1;
    u_clear_max = 1'b0;
    chk("clr_idle_max_valid", u_max_valid, 0);
    chk("clr_idle_max", u_max_out, 0);
    chk("clr_idle_idx", u_max_idx, 0);
    chk("clr_idle_dot", u_dot_out, 1000);
    vec4(0, 0, 8'd1, 8'd1, 8'd1, 8'd1);
    wait_result(0, cyc);
    chk("clr_first_max", u_max_out, 10);
    chk("clr_first_idx", u_max_idx, 0);
    chk("clr_first_max_valid", u_max_valid, 1);

    // signed: weights -1, inputs 1 -> -4
    vec4(1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vec4(1, 0, 8'd1, 8'd1, 8'd1, 8'd1);
    wait_result(1, cyc);
    chk("s0_latency", cyc, 5);
    chk("s0_dot", s_dot_out, 64'h3FFFC);
    chk("s0_max", s_max_out, 64'h3FFFC);
    chk("s0_idx", s_max_idx, 0);
    vec4(1, 0, 8'd2, 8'd2, 8'd2, 8'd2);
    wait_result(1, cyc);
    chk("s1_dot", s_dot_out, 64'h3FFF8);
    chk("s1_max_kept", s_max_out, 64'h3FFFC);
    chk("s1_idx", s_max_idx, 0);
    vec4(1, 0, 8'hFE, 8'hFE, 8'hFE, 8'hFE);
    wait_result(1, cyc);
    chk("s2_dot", s_dot_out, 8);
    chk("s2_max", s_max_out, 8);
    chk("s2_idx", s_max_idx, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
